// File: rtl/snn_bitmap_loader.sv
// -----------------------------------------------------------------------------
// snn_bitmap_loader
//   Front end for the SNN digit-recognition core. Receives a 784-pixel 1-bit
//   bitmap as 98 UART bytes, unpacks each byte LSB first into eight single-bit
//   writes to the input-unit RAM, pulses the core's start once the image is
//   complete, waits for the core's result and hands the ASCII digit to the
//   UART transmitter.
//
// Ports
//   clk, rst_n   : system clock (rising edge), asynchronous active-low reset
//   rx_rdy       : one-cycle strobe, rx_data valid in that cycle
//   rx_data[7:0] : received byte; bit i of byte k is pixel 8k+i
//   core_addr    : input-unit read address from the core (muxed onto ram_addr)
//   core_done    : one-cycle strobe, core_digit valid in that cycle
//   core_digit   : classification result
//   tx_busy      : UART transmitter busy
//   ram_addr     : input-unit RAM address (bit counter while loading)
//   ram_d/ram_we : RAM write data / enable
//   core_start   : one-cycle start pulse to the core
//   tx_start     : one-cycle transmit request
//   tx_data      : ASCII digit, held until the next frame result
//   busy         : high in every state except LOAD_IDLE
//   overflow     : sticky, a byte was lost while the holding register was full
// -----------------------------------------------------------------------------
module snn_bitmap_loader #(
    parameter int unsigned NUM_BITS   = 784,
    parameter int unsigned NUM_BYTES  = 98,
    parameter logic [7:0]  ASCII_BASE = 8'h30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    input  logic [9:0] core_addr,
    input  logic       core_done,
    input  logic [3:0] core_digit,
    input  logic       tx_busy,
    output logic [9:0] ram_addr,
    output logic       ram_d,
    output logic       ram_we,
    output logic       core_start,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       overflow
);

    typedef enum logic [2:0] {
        LOAD_IDLE,
        UNPACK,
        START,
        WAIT_CORE,
        SEND
    } state_t;

    localparam logic [9:0] LP_LAST_BIT  = 10'(NUM_BITS - 1);
    localparam logic [6:0] LP_NUM_BYTES = 7'(NUM_BYTES);

    state_t     r_state;
    logic [7:0] r_shift;
    logic [9:0] r_bit_cnt;
    logic [2:0] r_sub_cnt;
    logic [6:0] r_byte_cnt;
    logic [7:0] r_hold;
    logic       r_hold_vld;
    logic       r_overflow;
    logic [7:0] r_tx_data;

    logic w_byte_end;
    logic w_last_bit;
    logic w_room;
    logic w_drain;

    assign w_byte_end = (r_state == UNPACK) && (r_sub_cnt == 3'd7);
    assign w_last_bit = w_byte_end && (r_bit_cnt == LP_LAST_BIT);
    assign w_room     = (r_byte_cnt != LP_NUM_BYTES);
    // Hold register empties this cycle: picked up from idle, or reloaded
    // back-to-back at the end of a byte that is not the last of the frame.
    assign w_drain    = r_hold_vld &&
                        (((r_state == LOAD_IDLE) && w_room) ||
                         (w_byte_end && !w_last_bit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= LOAD_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_sub_cnt  <= '0;
            r_byte_cnt <= '0;
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_overflow <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            case (r_state)
                LOAD_IDLE: begin
                    if (w_room && (r_hold_vld || rx_rdy)) begin
                        r_shift    <= r_hold_vld ? r_hold : rx_data;
                        r_sub_cnt  <= '0;
                        r_byte_cnt <= r_byte_cnt + 7'd1;
                        r_state    <= UNPACK;
                    end
                end
                UNPACK: begin
                    r_shift   <= {1'b0, r_shift[7:1]};
                    r_sub_cnt <= r_sub_cnt + 3'd1;
                    if (w_last_bit) begin
                        // Counter stays on the final address; START clears it.
                        r_state <= START;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 10'd1;
                        if (w_byte_end) begin
                            if (r_hold_vld) begin
                                r_shift    <= r_hold;
                                r_byte_cnt <= r_byte_cnt + 7'd1;
                            end else begin
                                r_state <= LOAD_IDLE;
                            end
                        end
                    end
                end
                START: begin
                    r_bit_cnt  <= '0;
                    r_byte_cnt <= '0;
                    r_state    <= WAIT_CORE;
                end
                WAIT_CORE: begin
                    if (core_done) begin
                        r_tx_data <= ASCII_BASE + {4'b0000, core_digit};
                        r_state   <= SEND;
                    end
                end
                SEND: begin
                    if (!tx_busy) begin
                        r_state <= LOAD_IDLE;
                    end
                end
                default: r_state <= LOAD_IDLE;
            endcase

            // Holding register: a drain in this cycle frees the slot, so a
            // byte arriving in the same cycle can refill it.
            if (r_state == START) begin
                r_hold_vld <= 1'b0;
            end else if (rx_rdy && ((r_state == UNPACK) ||
                                    ((r_state == LOAD_IDLE) && r_hold_vld))) begin
                if (!r_hold_vld || w_drain) begin
                    r_hold     <= rx_data;
                    r_hold_vld <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (w_drain) begin
                r_hold_vld <= 1'b0;
            end
        end
    end

    assign ram_we     = (r_state == UNPACK);
    assign ram_d      = r_shift[0];
    assign ram_addr   = ((r_state == LOAD_IDLE) || (r_state == UNPACK)) ? r_bit_cnt : core_addr;
    assign core_start = (r_state == START);
    assign tx_start   = (r_state == SEND) && !tx_busy;
    assign busy       = (r_state != LOAD_IDLE);
    assign overflow   = r_overflow;
    assign tx_data    = r_tx_data;

endmodule

// File: doc/snn_bitmap_loader.md
Name: snn_bitmap_loader

Overview:
- Upstream front end for the SNN digit-recognition core.
- Accepts a 784-pixel 1-bit bitmap as 98 bytes from the UART receiver and unpacks each byte into eight single-bit writes to the input-unit RAM.
- Once the image is complete, pulses the core's start, owns the RAM address mux while loading, and waits for the core's done.
- Converts the resulting digit to ASCII and hands it to the UART transmitter.

Parameters:
- NUM_BITS, 784: pixels per image; total RAM bit writes per frame.
- NUM_BYTES, 98: bytes per frame, equal to NUM_BITS/8.
- ASCII_BASE, 8'h30: offset added to the digit for the transmit byte.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_rdy  in  1  one-cycle strobe; rx_data is valid in that cycle.
- rx_data  in  8  received byte. Bit i of byte k is pixel 8k+i, LSB first.
- core_addr  in  10  input-unit read address driven by the SNN core.
- core_done  in  1  one-cycle strobe from the core; classification is finished.
- core_digit  in  4  core result; valid in the core_done cycle.
- tx_busy  in  1  UART transmitter busy.
- ram_addr  out  10  input-unit RAM address (muxed).
- ram_d  out  1  RAM write data.
- ram_we  out  1  RAM write enable.
- core_start  out  1  one-cycle start pulse to the core.
- tx_start  out  1  one-cycle transmit request.
- tx_data  out  8  ASCII digit, held stable from tx_start until the next frame result.
- busy  out  1  high in every state except LOAD_IDLE.
- overflow  out  1  sticky; a byte was lost while the holding register was full.

Behaviour:
- Reset (async): state LOAD_IDLE, bit_cnt=0, byte_cnt=0, hold_vld=0, overflow=0, tx_data=8'h00.
  - All strobes low: ram_we, core_start, tx_start.
  - ram_addr follows the mux rule below (bit_cnt=0 while loading states are active).
  - Reset mid-frame discards the partial image; no core_start is issued.
- Registers:
  - shift[7:0]: byte being unpacked.
  - bit_cnt[9:0]: RAM write address.
  - sub_cnt[2:0]: bit index within the current byte.
  - byte_cnt[6:0]: bytes accepted this frame.
  - hold[7:0] with hold_vld: one-deep holding register.
- Address mux:
  - ram_addr = bit_cnt in LOAD_IDLE and UNPACK; core_addr in all other states.
  - ram_we is never asserted outside UNPACK.
- LOAD_IDLE:
  - If hold_vld, load shift from hold and clear hold_vld. Else if rx_rdy, load shift from rx_data.
  - Either case: sub_cnt=0, byte_cnt+1, go to UNPACK.
- UNPACK (8 cycles per byte):
  - Each cycle: ram_we=1, ram_d=shift[0], ram_addr=bit_cnt.
  - Then shift>>=1, bit_cnt+1, sub_cnt+1.
  - Latency: a byte strobed in cycle t is written in cycles t+1..t+8.
  - When sub_cnt=7 and bit_cnt=NUM_BITS-1 (write to 783): go to START.
  - When sub_cnt=7 otherwise: if hold_vld, reload shift from hold directly, clear hold_vld, stay in UNPACK (back-to-back, no bubble); else go to LOAD_IDLE.
- Holding register:
  - rx_rdy during UNPACK with hold_vld=0: capture into hold, set hold_vld.
  - rx_rdy with hold_vld=1: byte dropped, overflow set.
  - rx_rdy in the same cycle hold is drained: capture is allowed (drain takes priority, then refill).
- START:
  - core_start=1 for exactly one cycle.
  - Clear bit_cnt, byte_cnt, hold_vld. Go to WAIT_CORE.
- WAIT_CORE:
  - rx_rdy is ignored; bytes are dropped and overflow is NOT set.
  - On core_done: tx_data = ASCII_BASE + core_digit, go to SEND.
  - core_done in any other state is ignored.
- SEND:
  - When tx_busy=0: tx_start=1 for one cycle, go to LOAD_IDLE.
  - Otherwise wait in SEND.
- Frame boundary:
  - The 99th byte is treated as byte 0 of the next frame only if it arrives in LOAD_IDLE after SEND.
  - bit_cnt never exceeds 783 (no wrap within a frame).

Test Plan:
- Reset, then 98 bytes of 8'hA5 spaced 20 cycles -> 784 writes, ram_d pattern 1,0,1,0,0,1,0,1 repeating at addresses 0..783; core_start once, 1 cycle after the addr-783 write.
- Byte 8'h01 at t, second byte at t+3 -> second byte held; writes run contiguously t+1..t+16 with no bubble; overflow=0.
- Three rx_rdy strobes at t, t+1, t+2 -> third byte dropped, overflow=1 and remains 1 until reset.
- After core_start, drive core_addr=10'h123, then core_done with core_digit=7 while tx_busy=1 for 5 cycles -> ram_addr=10'h123; tx_start waits 5 cycles then pulses once; tx_data=8'h37.
- rx_rdy strobes during WAIT_CORE -> no ram_we, overflow stays 0; the next frame still starts at address 0.
- rst_n low after 40 bytes, then a full 98-byte frame -> writes restart at address 0; exactly one core_start, after 784 writes.
